// File: rtl/spdif_frame_sequencer_if.sv
// S/PDIF frame sequencer bus.
// Groups the run control, the sample handshake and the slot-stream outputs.
//   master : sample source / line-coder side (drives enable, bit_tick, samples)
//   slave  : the sequencer itself
// Signals:
//   enable         run request, sampled at frame boundaries
//   bit_tick       one-cycle strobe per S/PDIF time slot
//   sample_valid   left/right pair available
//   sample_l/_r    two's complement samples, WIDTH bits
//   sample_ready   pulse: pair accepted this cycle
//   slot_data      data bit of the current slot
//   preamble       0 none, 1 B, 2 M, 3 W
//   subframe_start pulse at slot 0 of every subframe
//   frame_cnt      frame index within the 192-frame block
//   underrun       pulse: no pair at a frame boundary
//   busy           sequencer not idle
interface spdif_frame_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             enable;
  logic             bit_tick;
  logic             sample_valid;
  logic [WIDTH-1:0] sample_l;
  logic [WIDTH-1:0] sample_r;
  logic             sample_ready;
  logic             slot_data;
  logic [1:0]       preamble;
  logic             subframe_start;
  logic [7:0]       frame_cnt;
  logic             underrun;
  logic             busy;

  modport master (
    output enable,
    output bit_tick,
    output sample_valid,
    output sample_l,
    output sample_r,
    input  sample_ready,
    input  slot_data,
    input  preamble,
    input  subframe_start,
    input  frame_cnt,
    input  underrun,
    input  busy
  );

  modport slave (
    input  enable,
    input  bit_tick,
    input  sample_valid,
    input  sample_l,
    input  sample_r,
    output sample_ready,
    output slot_data,
    output preamble,
    output subframe_start,
    output frame_cnt,
    output underrun,
    output busy
  );
endinterface

// File: rtl/spdif_frame_sequencer.sv
// S/PDIF frame sequencer.
// Accepts left/right sample pairs and serialises them into 32-slot subframes
// (preamble, LSB-first audio, V/U/C = 0, even parity), one slot per bit_tick.
// Ports:
//   clock   system clock, rising edge
//   nreset  asynchronous active-low reset
//   bus     spdif_frame_sequencer_if.slave (handshake, tick, slot stream)
// WIDTH is the sample width, legal range 16..24.
module spdif_frame_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input logic                    clock,
  input logic                    nreset,
  spdif_frame_sequencer_if.slave bus
);

  localparam logic [4:0] LastSlot  = 5'd31;
  localparam logic [4:0] LastAudio = 5'd27;
  localparam logic [7:0] LastFrame = 8'd191;
  localparam logic [1:0] PreNone   = 2'd0;
  localparam logic [1:0] PreB      = 2'd1;
  localparam logic [1:0] PreM      = 2'd2;
  localparam logic [1:0] PreW      = 2'd3;

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e           state_q, state_d;
  logic [4:0]       slot_q, slot_d;
  logic             chan_q, chan_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [WIDTH-1:0] lat_l_q, lat_l_d;
  logic [WIDTH-1:0] lat_r_q, lat_r_d;
  logic             slot_data_q, slot_data_d;
  logic [1:0]       preamble_q, preamble_d;
  logic             sub_start_q, sub_start_d;
  logic             sample_ready;
  logic             underrun;

  logic [WIDTH-1:0] cur_sample;
  logic [23:0]      aud_word;
  logic [4:0]       aud_idx;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      slot_q      <= '0;
      chan_q      <= 1'b0;
      frame_cnt_q <= '0;
      lat_l_q     <= '0;
      lat_r_q     <= '0;
      slot_data_q <= 1'b0;
      preamble_q  <= PreNone;
      sub_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      chan_q      <= chan_d;
      frame_cnt_q <= frame_cnt_d;
      lat_l_q     <= lat_l_d;
      lat_r_q     <= lat_r_d;
      slot_data_q <= slot_data_d;
      preamble_q  <= preamble_d;
      sub_start_q <= sub_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    chan_d       = chan_q;
    frame_cnt_d  = frame_cnt_q;
    lat_l_d      = lat_l_q;
    lat_r_d      = lat_r_q;
    sub_start_d  = 1'b0;
    sample_ready = 1'b0;
    underrun     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.enable) state_d = StWait;
      end
      StWait: begin
        // A withdrawn run request wins over a pair offered in the same cycle.
        if (!bus.enable) begin
          state_d = StIdle;
        end else if (bus.sample_valid) begin
          sample_ready = 1'b1;
          lat_l_d      = bus.sample_l;
          lat_r_d      = bus.sample_r;
          slot_d       = '0;
          chan_d       = 1'b0;
          sub_start_d  = 1'b1;
          state_d      = StSend;
        end
      end
      StSend: begin
        if (bus.bit_tick) begin
          if (slot_q != LastSlot) begin
            slot_d = slot_q + 5'd1;
          end else begin
            slot_d = '0;
            if (!chan_q) begin
              chan_d      = 1'b1;
              sub_start_d = 1'b1;
            end else if (!bus.enable) begin
              // Stop cleanly at the frame boundary; frame_cnt is kept.
              chan_d  = 1'b0;
              state_d = StIdle;
            end else begin
              chan_d      = 1'b0;
              sub_start_d = 1'b1;
              frame_cnt_d = (frame_cnt_q == LastFrame) ? 8'd0 : frame_cnt_q + 8'd1;
              if (bus.sample_valid) begin
                sample_ready = 1'b1;
                lat_l_d      = bus.sample_l;
                lat_r_d      = bus.sample_r;
              end else begin
                // Keep the line alive with digital silence.
                underrun = 1'b1;
                lat_l_d  = '0;
                lat_r_d  = '0;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Slot outputs are precomputed from next state so the registers present
    // the new slot one clock after its causing tick.
    cur_sample  = chan_d ? lat_r_d : lat_l_d;
    // Left-justify into the 24-bit audio field: field bit 0 is slot 4.
    aud_word    = 24'(cur_sample) << (24 - WIDTH);
    aud_idx     = slot_d - 5'd4;
    slot_data_d = 1'b0;
    preamble_d  = PreNone;
    if (state_d == StSend) begin
      if (slot_d < 5'd4) begin
        preamble_d = chan_d ? PreW : ((frame_cnt_d == 8'd0) ? PreB : PreM);
      end else if (slot_d <= LastAudio) begin
        slot_data_d = aud_word[aud_idx];
      end else if (slot_d == LastSlot) begin
        // V, U and C are always 0, so parity covers the audio bits only.
        slot_data_d = ^cur_sample;
      end
    end
  end

  assign bus.sample_ready   = sample_ready;
  assign bus.underrun       = underrun;
  assign bus.slot_data      = slot_data_q;
  assign bus.preamble       = preamble_q;
  assign bus.subframe_start = sub_start_q;
  assign bus.frame_cnt      = frame_cnt_q;
  assign bus.busy           = (state_q != StIdle);

endmodule
